// File: rtl/scoreboard_if.sv
// Scoreboard record types and the issue/commit/writeback bundle.
package scoreboard_pkg;
    localparam int NR_SB_ENTRIES = 4;
    localparam int NR_WB_PORTS   = 3;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception                 ex;
    } scoreboard_entry;
endpackage

interface scoreboard_if #(
    parameter int NR_ENTRIES  = scoreboard_pkg::NR_SB_ENTRIES,
    parameter int NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
);
    localparam int TIDW = $clog2(NR_ENTRIES);

    scoreboard_pkg::scoreboard_entry decoded_instr_i;
    logic                            decoded_instr_valid_i;
    logic                            decoded_instr_ack_o;
    logic [TIDW-1:0]                 issue_trans_id_o;

    scoreboard_pkg::scoreboard_entry commit_instr_o;
    logic                            commit_valid_o;
    logic                            commit_ack_i;

    logic [NR_WB_PORTS-1:0]                  wb_valid_i;
    logic [NR_WB_PORTS-1:0][TIDW-1:0]        wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][63:0]            wb_data_i;
    scoreboard_pkg::exception [NR_WB_PORTS-1:0] wb_ex_i;

    modport master (
        output decoded_instr_i, decoded_instr_valid_i,
        output commit_ack_i,
        output wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
        input  decoded_instr_ack_o, issue_trans_id_o,
        input  commit_instr_o, commit_valid_o
    );

    modport slave (
        input  decoded_instr_i, decoded_instr_valid_i,
        input  commit_ack_i,
        input  wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
        output decoded_instr_ack_o, issue_trans_id_o,
        output commit_instr_o, commit_valid_o
    );
endinterface

// File: rtl/scoreboard.sv
// In-order scoreboard between issue and commit.
// Define SB_FORWARD_EN to add the rs1/rs2 operand-forwarding lookup.
module scoreboard #(
    parameter int NR_ENTRIES  = scoreboard_pkg::NR_SB_ENTRIES,
    parameter int NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    output logic        full_o,
    scoreboard_if.slave sb,
    output logic [31:0] rd_clobber_o
`ifdef SB_FORWARD_EN
    ,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [63:0] rs1_o,
    output logic [63:0] rs2_o,
    output logic        rs1_valid_o,
    output logic        rs2_valid_o
`endif
);
    import scoreboard_pkg::*;

    localparam int TIDW = $clog2(NR_ENTRIES);
    localparam int CW   = TIDW + 1;

    scoreboard_entry       r_mem [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] r_occ;
    logic [TIDW-1:0]       r_head;
    logic [TIDW-1:0]       r_tail;
    logic [CW-1:0]         r_cnt;

    logic            w_issue;
    logic            w_commit;
    logic [31:0]     w_clobber;
    scoreboard_entry w_new;

    assign full_o   = (r_cnt == CW'(NR_ENTRIES));
    assign w_issue  = sb.decoded_instr_valid_i & ~full_o & ~flush_i;
    assign w_commit = sb.commit_valid_o & sb.commit_ack_i;

    assign sb.decoded_instr_ack_o = w_issue;
    assign sb.issue_trans_id_o    = r_tail;
    assign sb.commit_instr_o      = r_mem[r_head];
    assign sb.commit_valid_o      = r_occ[r_head] & r_mem[r_head].valid;

    always_comb begin
        w_new          = sb.decoded_instr_i;
        w_new.trans_id = r_tail;
    end

    always_comb begin
        w_clobber = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (r_occ[i]) w_clobber[r_mem[i].rd] = 1'b1;
        end
        w_clobber[0] = 1'b0;
    end
    assign rd_clobber_o = w_clobber;

    // Later ports overwrite earlier ones; a commit of the head drops its writeback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) r_mem[i] <= '0;
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (flush_i) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            for (int k = 0; k < NR_WB_PORTS; k++) begin
                if (sb.wb_valid_i[k] && r_occ[sb.wb_trans_id_i[k]] &&
                    !(w_commit && sb.wb_trans_id_i[k] == r_head)) begin
                    r_mem[sb.wb_trans_id_i[k]].result <= sb.wb_data_i[k];
                    r_mem[sb.wb_trans_id_i[k]].valid  <= 1'b1;
                    if (sb.wb_ex_i[k].valid)
                        r_mem[sb.wb_trans_id_i[k]].ex <= sb.wb_ex_i[k];
                end
            end
            if (w_issue) begin
                r_mem[r_tail] <= w_new;
                r_occ[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_commit) begin
                r_occ[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            unique case ({w_issue, w_commit})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef SB_FORWARD_EN
    // Walk oldest to youngest so the youngest match is the one left standing.
    function automatic logic [64:0] fwd_lookup(input logic [4:0] rs);
        logic [64:0]     res;
        logic [TIDW-1:0] idx;
        res = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            idx = r_head + TIDW'(i);
            if (CW'(i) < r_cnt && r_mem[idx].rd == rs)
                res = r_mem[idx].valid ? {1'b1, r_mem[idx].result} : '0;
        end
        if (rs == 5'd0) res = '0;
        return res;
    endfunction

    logic [64:0] w_fwd1;
    logic [64:0] w_fwd2;

    always_comb begin
        w_fwd1 = fwd_lookup(rs1_i);
        w_fwd2 = fwd_lookup(rs2_i);
    end

    assign rs1_valid_o = w_fwd1[64];
    assign rs1_o       = w_fwd1[63:0];
    assign rs2_valid_o = w_fwd2[64];
    assign rs2_o       = w_fwd2[63:0];
`endif
endmodule

// File: tb/tb_scoreboard.sv
// Directed-vector bench for the in-order scoreboard.
module tb_scoreboard;
    import scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_ni;
    logic flush_i;
    logic full_o;
    logic [31:0] rd_clobber_o;
`ifdef SB_FORWARD_EN
    logic [4:0]  rs1_i, rs2_i;
    logic [63:0] rs1_o, rs2_o;
    logic        rs1_valid_o, rs2_valid_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    scoreboard_if sbi ();

    scoreboard dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .full_o       (full_o),
        .sb           (sbi.slave),
        .rd_clobber_o (rd_clobber_o)
`ifdef SB_FORWARD_EN
        ,
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .rs1_valid_o  (rs1_valid_o),
        .rs2_valid_o  (rs2_valid_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic scoreboard_entry mk(input logic [63:0] pc,
                                           input logic [4:0] rd,
                                           input logic v);
        scoreboard_entry e;
        e          = '0;
        e.pc       = pc;
        e.rd       = rd;
        e.valid    = v;
        e.trans_id = '1;
        return e;
    endfunction

    task automatic idle();
        flush_i                   = 1'b0;
        sbi.decoded_instr_i       = '0;
        sbi.decoded_instr_valid_i = 1'b0;
        sbi.commit_ack_i          = 1'b0;
        sbi.wb_valid_i            = '0;
        sbi.wb_trans_id_i         = '0;
        sbi.wb_data_i             = '0;
        sbi.wb_ex_i               = '0;
    endtask

    task automatic wb(input int k, input int id, input logic [63:0] d);
        sbi.wb_valid_i[k]    = 1'b1;
        sbi.wb_trans_id_i[k] = 2'(id);
        sbi.wb_data_i[k]     = d;
    endtask

    task automatic issue(input logic [63:0] pc, input logic [4:0] rd,
                         input logic v, input int exp_id);
        sbi.decoded_instr_i       = mk(pc, rd, v);
        sbi.decoded_instr_valid_i = 1'b1;
        #1;
        check("issue_ack", 64'(sbi.decoded_instr_ack_o), 64'd1);
        check("issue_id", 64'(sbi.issue_trans_id_o), 64'(exp_id));
        tick();
        sbi.decoded_instr_valid_i = 1'b0;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
`ifdef SB_FORWARD_EN
        rs1_i = '0;
        rs2_i = '0;
`endif
        #2;
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_cvalid", 64'(sbi.commit_valid_o), 64'd0);
        check("rst_cpc", sbi.commit_instr_o.pc, 64'd0);
        check("rst_clobber", 64'(rd_clobber_o), 64'd0);
        check("rst_id", 64'(sbi.issue_trans_id_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // fill, full, first writeback
        for (int i = 0; i < 4; i++) issue(64'(i), 5'(i + 1), 1'b0, i);
        check("fill_full", 64'(full_o), 64'd1);
        check("fill_clobber", 64'(rd_clobber_o), 64'h1E);
        check("fill_cvalid", 64'(sbi.commit_valid_o), 64'd0);
        sbi.decoded_instr_i       = mk(64'd99, 5'd9, 1'b0);
        sbi.decoded_instr_valid_i = 1'b1;
        #1;
        check("full_ack", 64'(sbi.decoded_instr_ack_o), 64'd0);
        sbi.decoded_instr_valid_i = 1'b0;
        wb(0, 0, 64'hDEAD);
        tick();
        idle();
        check("wb_cvalid", 64'(sbi.commit_valid_o), 64'd1);
        check("wb_result", sbi.commit_instr_o.result, 64'hDEAD);

        // full blocks issue even alongside a commit
        sbi.decoded_instr_i       = mk(64'd4, 5'd0, 1'b1);
        sbi.decoded_instr_valid_i = 1'b1;
        sbi.commit_ack_i          = 1'b1;
        #1;
        check("full_commit_ack", 64'(sbi.decoded_instr_ack_o), 64'd0);
        tick();
        idle();
        check("after_commit_full", 64'(full_o), 64'd0);
        check("head1_cvalid", 64'(sbi.commit_valid_o), 64'd0);
        check("head1_clobber", 64'(rd_clobber_o), 64'h1C);
        wb(0, 1, 64'h101);
        wb(1, 2, 64'h102);
        wb(2, 3, 64'h103);
        tick();
        idle();
        check("head1_pc", sbi.commit_instr_o.pc, 64'd1);
        check("head1_result", sbi.commit_instr_o.result, 64'h101);

        // 10 issue+commit pairs across the tail wrap
        for (int j = 0; j < 10; j++) begin
            sbi.decoded_instr_i       = mk(64'(4 + j), 5'd0, 1'b1);
            sbi.decoded_instr_valid_i = 1'b1;
            sbi.commit_ack_i          = 1'b1;
            #1;
            check("pair_ack", 64'(sbi.decoded_instr_ack_o), 64'd1);
            check("pair_id", 64'(sbi.issue_trans_id_o), 64'((4 + j) % 4));
            check("pair_cpc", sbi.commit_instr_o.pc, 64'(1 + j));
            check("pair_ctid", 64'(sbi.commit_instr_o.trans_id),
                  64'((1 + j) % 4));
            check("pair_full", 64'(full_o), 64'd0);
            tick();
        end
        idle();
        for (int d = 0; d < 3; d++) begin
            sbi.commit_ack_i = 1'b1;
            #1;
            check("drain_cvalid", 64'(sbi.commit_valid_o), 64'd1);
            check("drain_cpc", sbi.commit_instr_o.pc, 64'(11 + d));
            tick();
        end
        idle();
        check("empty_cvalid", 64'(sbi.commit_valid_o), 64'd0);

        // flush with a concurrent issue request
        issue(64'd50, 5'd3, 1'b0, 2);
        issue(64'd51, 5'd4, 1'b0, 3);
        issue(64'd52, 5'd5, 1'b0, 0);
        check("pre_flush_clobber", 64'(rd_clobber_o), 64'h38);
        flush_i                   = 1'b1;
        sbi.decoded_instr_i       = mk(64'd53, 5'd6, 1'b1);
        sbi.decoded_instr_valid_i = 1'b1;
        #1;
        check("flush_ack", 64'(sbi.decoded_instr_ack_o), 64'd0);
        tick();
        idle();
        check("flush_cvalid", 64'(sbi.commit_valid_o), 64'd0);
        check("flush_clobber", 64'(rd_clobber_o), 64'd0);
        check("flush_id", 64'(sbi.issue_trans_id_o), 64'd0);

        // out-of-order writeback, in-order commit
        for (int i = 0; i < 3; i++) issue(64'(20 + i), 5'(i + 1), 1'b0, i);
        wb(0, 2, 64'hA2);
        tick();
        idle();
        check("ooo_wait2", 64'(sbi.commit_valid_o), 64'd0);
        wb(1, 1, 64'hA1);
        tick();
        idle();
        check("ooo_wait1", 64'(sbi.commit_valid_o), 64'd0);
        wb(2, 0, 64'hA0);
        tick();
        idle();
        for (int d = 0; d < 3; d++) begin
            sbi.commit_ack_i = 1'b1;
            #1;
            check("ooo_cvalid", 64'(sbi.commit_valid_o), 64'd1);
            check("ooo_cpc", sbi.commit_instr_o.pc, 64'(20 + d));
            check("ooo_result", sbi.commit_instr_o.result, 64'(8'hA0 + d));
            tick();
        end
        idle();

        // port conflict and exception capture
        flush_i = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) issue(64'(30 + i), 5'(i + 8), 1'b0, i);
        wb(0, 1, 64'h11);
        wb(2, 1, 64'h22);
        wb(1, 0, 64'h55);
        sbi.wb_ex_i[1].valid = 1'b1;
        sbi.wb_ex_i[1].cause = 64'd5;
        tick();
        idle();
        check("ex_cvalid", 64'(sbi.commit_valid_o), 64'd1);
        check("ex_cause", sbi.commit_instr_o.ex.cause, 64'd5);
        check("ex_valid", 64'(sbi.commit_instr_o.ex.valid), 64'd1);
        check("ex_result", sbi.commit_instr_o.result, 64'h55);
        sbi.commit_ack_i = 1'b1;
        tick();
        idle();
        check("conflict_pc", sbi.commit_instr_o.pc, 64'd31);
        check("conflict_result", sbi.commit_instr_o.result, 64'h22);
        check("conflict_noex", 64'(sbi.commit_instr_o.ex.valid), 64'd0);

        // asynchronous reset mid-operation
        issue(64'd33, 5'd12, 1'b1, 3);
        check("prerst_clobber", 64'(rd_clobber_o), 64'h1600);
        rst_ni = 1'b0;
        #1;
        check("arst_cvalid", 64'(sbi.commit_valid_o), 64'd0);
        check("arst_clobber", 64'(rd_clobber_o), 64'd0);
        check("arst_id", 64'(sbi.issue_trans_id_o), 64'd0);
        check("arst_cpc", sbi.commit_instr_o.pc, 64'd0);
        #2;
        rst_ni = 1'b1;
        issue(64'd40, 5'd7, 1'b1, 0);
        check("post_rst_cvalid", 64'(sbi.commit_valid_o), 64'd1);
        check("post_rst_cpc", sbi.commit_instr_o.pc, 64'd40);
        check("post_rst_clobber", 64'(rd_clobber_o), 64'h80);

`ifdef SB_FORWARD_EN
        flush_i = 1'b1;
        tick();
        idle();
        issue(64'd60, 5'd5, 1'b0, 0);
        issue(64'd61, 5'd5, 1'b0, 1);
        wb(0, 0, 64'd7);
        tick();
        idle();
        rs1_i = 5'd5;
        rs2_i = 5'd6;
        #1;
        check("fwd_young_busy", 64'(rs1_valid_o), 64'd0);
        check("fwd_young_data", rs1_o, 64'd0);
        check("fwd_nomatch", 64'(rs2_valid_o), 64'd0);
        wb(1, 1, 64'd9);
        tick();
        idle();
        check("fwd_valid", 64'(rs1_valid_o), 64'd1);
        check("fwd_data", rs1_o, 64'd9);
        rs2_i = 5'd0;
        #1;
        check("fwd_x0", 64'(rs2_valid_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
